// File: rtl/anti_theft_pkg.sv
// Shared types and default intervals for the anti-theft controller.
package anti_theft_pkg;

  typedef enum logic [2:0] {
    ARMED       = 3'd0,
    TRIGGERED   = 3'd1,
    SOUND_ALARM = 3'd2,
    ALARM_HOLD  = 3'd3,
    DISARMED    = 3'd4,
    WAIT_OPEN   = 3'd5,
    WAIT_CLOSE  = 3'd6,
    ARMING      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    SEL_ARM       = 2'd0,
    SEL_DRIVER    = 2'd1,
    SEL_PASSENGER = 2'd2,
    SEL_ALARM     = 2'd3
  } interval_sel_t;

  localparam logic [3:0] DEF_ARM_DELAY       = 4'd6;
  localparam logic [3:0] DEF_DRIVER_DELAY    = 4'd8;
  localparam logic [3:0] DEF_PASSENGER_DELAY = 4'd15;
  localparam logic [3:0] DEF_ALARM_ON        = 4'd10;

endpackage

// File: rtl/anti_theft_fsm_time_parameters.sv
// Maps an interval select code to its 4-bit duration.
// With REPROGRAM_EN defined the four durations live in run-time writable registers.
module time_parameters
  import anti_theft_pkg::*;
#(
  parameter logic [3:0] T_ARM_DELAY       = DEF_ARM_DELAY,
  parameter logic [3:0] T_DRIVER_DELAY    = DEF_DRIVER_DELAY,
  parameter logic [3:0] T_PASSENGER_DELAY = DEF_PASSENGER_DELAY,
  parameter logic [3:0] T_ALARM_ON        = DEF_ALARM_ON
) (
`ifdef REPROGRAM_EN
  input  logic          clock,
  input  logic          reset,
  input  logic          reprogram,
  input  logic [1:0]    paramSel,
  input  logic [3:0]    paramValue,
`endif
  input  interval_sel_t sel,
  output logic [3:0]    interval
);

  logic [3:0] arm_r, drv_r, pas_r, alm_r;

`ifdef REPROGRAM_EN
  // A zero write means "back to the built-in default".
  function automatic logic [3:0] pick(input logic [3:0] v, input logic [3:0] d);
    return (v == 4'd0) ? d : v;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      arm_r <= T_ARM_DELAY;
      drv_r <= T_DRIVER_DELAY;
      pas_r <= T_PASSENGER_DELAY;
      alm_r <= T_ALARM_ON;
    end else if (reprogram) begin
      case (paramSel)
        2'd0: arm_r <= pick(paramValue, T_ARM_DELAY);
        2'd1: drv_r <= pick(paramValue, T_DRIVER_DELAY);
        2'd2: pas_r <= pick(paramValue, T_PASSENGER_DELAY);
        2'd3: alm_r <= pick(paramValue, T_ALARM_ON);
      endcase
    end
  end
`else
  assign arm_r = T_ARM_DELAY;
  assign drv_r = T_DRIVER_DELAY;
  assign pas_r = T_PASSENGER_DELAY;
  assign alm_r = T_ALARM_ON;
`endif

  always_comb begin
    interval = arm_r;
    case (sel)
      SEL_ARM:       interval = arm_r;
      SEL_DRIVER:    interval = drv_r;
      SEL_PASSENGER: interval = pas_r;
      SEL_ALARM:     interval = alm_r;
      default:       interval = arm_r;
    endcase
  end

endmodule

// File: rtl/anti_theft_fsm.sv
// Vehicle anti-theft controller: synchronised switch inputs, alarm FSM, timer handshake.
// Optional REPROGRAM_EN adds run-time reprogramming of the four intervals.
module anti_theft_fsm
  import anti_theft_pkg::*;
#(
  parameter logic [3:0] T_ARM_DELAY       = DEF_ARM_DELAY,
  parameter logic [3:0] T_DRIVER_DELAY    = DEF_DRIVER_DELAY,
  parameter logic [3:0] T_PASSENGER_DELAY = DEF_PASSENGER_DELAY,
  parameter logic [3:0] T_ALARM_ON        = DEF_ALARM_ON
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       driverDoor,
  input  logic       passengerDoor,
  input  logic       expired,
  input  logic       clock1Hz,
`ifdef REPROGRAM_EN
  input  logic       reprogram,
  input  logic [1:0] paramSel,
  input  logic [3:0] paramValue,
`endif
  output logic       startTimer,
  output logic [3:0] value,
  output logic       siren,
  output logic       statusLed,
  output logic [2:0] state
);

  logic [2:0]    sw_p0, sw_p1;
  logic          ign_s, drv_s, pas_s, exp_ok;
  state_t        cur_state, nxt_state;
  logic          start_nxt, led_nxt;
  interval_sel_t sel_nxt;
  logic [3:0]    interval;

  // Two-flop synchroniser for the asynchronous switches
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_p0 <= 3'b000;
      sw_p1 <= 3'b000;
    end else begin
      sw_p0 <= {ignition, driverDoor, passengerDoor};
      sw_p1 <= sw_p0;
    end
  end

  assign ign_s  = sw_p1[2];
  assign drv_s  = sw_p1[1];
  assign pas_s  = sw_p1[0];
  // The timer cannot legitimately finish in the cycle it is being started.
  assign exp_ok = expired && !startTimer;

  time_parameters #(
    .T_ARM_DELAY      (T_ARM_DELAY),
    .T_DRIVER_DELAY   (T_DRIVER_DELAY),
    .T_PASSENGER_DELAY(T_PASSENGER_DELAY),
    .T_ALARM_ON       (T_ALARM_ON)
  ) u_time_parameters (
`ifdef REPROGRAM_EN
    .clock     (clock),
    .reset     (reset),
    .reprogram (reprogram),
    .paramSel  (paramSel),
    .paramValue(paramValue),
`endif
    .sel       (sel_nxt),
    .interval  (interval)
  );

  always_comb begin
    nxt_state = cur_state;
    start_nxt = 1'b0;
    sel_nxt   = SEL_ARM;
    led_nxt   = 1'b0;
    if (ign_s) begin
      nxt_state = DISARMED;
    end else begin
      case (cur_state)
        ARMED: begin
          if (drv_s) begin
            nxt_state = TRIGGERED;
            start_nxt = 1'b1;
            sel_nxt   = SEL_DRIVER;
          end else if (pas_s) begin
            nxt_state = TRIGGERED;
            start_nxt = 1'b1;
            sel_nxt   = SEL_PASSENGER;
          end
        end
        TRIGGERED:   if (exp_ok) nxt_state = SOUND_ALARM;
        SOUND_ALARM: begin
          if (!drv_s && !pas_s) begin
            nxt_state = ALARM_HOLD;
            start_nxt = 1'b1;
            sel_nxt   = SEL_ALARM;
          end
        end
        ALARM_HOLD: begin
          if (drv_s || pas_s) nxt_state = SOUND_ALARM;
          else if (exp_ok)    nxt_state = ARMED;
        end
        DISARMED:    nxt_state = WAIT_OPEN;
        WAIT_OPEN:   if (drv_s) nxt_state = WAIT_CLOSE;
        WAIT_CLOSE: begin
          if (!drv_s) begin
            nxt_state = ARMING;
            start_nxt = 1'b1;
            sel_nxt   = SEL_ARM;
          end
        end
        ARMING: begin
          if (drv_s || pas_s) nxt_state = WAIT_CLOSE;
          else if (exp_ok)    nxt_state = ARMED;
        end
        default:     nxt_state = ARMED;
      endcase
    end

    // Blink only while staying armed; every fresh entry starts dark.
    case (nxt_state)
      ARMED:                              led_nxt = (cur_state == ARMED) ? (statusLed ^ clock1Hz) : 1'b0;
      TRIGGERED, SOUND_ALARM, ALARM_HOLD: led_nxt = 1'b1;
      default:                            led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state  <= ARMED;
      startTimer <= 1'b0;
      value      <= 4'd0;
      statusLed  <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      startTimer <= start_nxt;
      statusLed  <= led_nxt;
      if (start_nxt) value <= interval;
    end
  end

  assign siren = (cur_state == SOUND_ALARM) || (cur_state == ALARM_HOLD);
  assign state = cur_state;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Directed plus randomised bench for anti_theft_fsm against a cycle-level behavioural model.
module tb_anti_theft_fsm;
  import anti_theft_pkg::*;

  logic clk = 1'b0;
  logic rst, ign, dd, pd, exp_in, hz;
`ifdef REPROGRAM_EN
  logic       rp;
  logic [1:0] psel;
  logic [3:0] pval;
`endif
  logic       start_o, siren_o, led_o;
  logic [3:0] val_o;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: what the outside world should see each cycle.
  state_t     ms;
  logic       mstart, mled;
  logic [3:0] mval;
  logic [2:0] ss1, ss2;
  logic [3:0] mparam [4];

  anti_theft_fsm dut (
    .clock        (clk),
    .reset        (rst),
    .ignition     (ign),
    .driverDoor   (dd),
    .passengerDoor(pd),
    .expired      (exp_in),
    .clock1Hz     (hz),
`ifdef REPROGRAM_EN
    .reprogram    (rp),
    .paramSel     (psel),
    .paramValue   (pval),
`endif
    .startTimer   (start_o),
    .value        (val_o),
    .siren        (siren_o),
    .statusLed    (led_o),
    .state        (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] def_of(input int i);
    case (i)
      0:       return 4'd6;
      1:       return 4'd8;
      2:       return 4'd15;
      default: return 4'd10;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_step();
    logic   i_s, d_s, p_s, e_ok, st, nl;
    state_t n;
    logic [3:0] nv;
    if (rst) begin
      ms = ARMED; mstart = 1'b0; mval = 4'd0; mled = 1'b0; ss1 = 3'b0; ss2 = 3'b0;
      for (int i = 0; i < 4; i++) mparam[i] = def_of(i);
    end else begin
      i_s = ss2[2]; d_s = ss2[1]; p_s = ss2[0];
      e_ok = exp_in && !mstart;
      n = ms; st = 1'b0; nv = mval;
      if (i_s) n = DISARMED;
      else if (ms == ARMED && (d_s || p_s)) begin
        n = TRIGGERED; st = 1'b1; nv = d_s ? mparam[1] : mparam[2];
      end else if (ms == TRIGGERED && e_ok) n = SOUND_ALARM;
      else if (ms == SOUND_ALARM && !d_s && !p_s) begin
        n = ALARM_HOLD; st = 1'b1; nv = mparam[3];
      end else if (ms == ALARM_HOLD) n = (d_s || p_s) ? SOUND_ALARM : (e_ok ? ARMED : ALARM_HOLD);
      else if (ms == DISARMED) n = WAIT_OPEN;
      else if (ms == WAIT_OPEN && d_s) n = WAIT_CLOSE;
      else if (ms == WAIT_CLOSE && !d_s) begin
        n = ARMING; st = 1'b1; nv = mparam[0];
      end else if (ms == ARMING) n = (d_s || p_s) ? WAIT_CLOSE : (e_ok ? ARMED : ARMING);
      if (n inside {TRIGGERED, SOUND_ALARM, ALARM_HOLD}) nl = 1'b1;
      else if (n == ARMED && ms == ARMED) nl = hz ? !mled : mled;
      else nl = 1'b0;
      ms = n; mstart = st; mval = nv; mled = nl;
      ss2 = ss1; ss1 = {ign, dd, pd};
`ifdef REPROGRAM_EN
      if (rp) mparam[psel] = (pval == 4'd0) ? def_of(int'(psel)) : pval;
`endif
    end
  endtask

  task automatic check_all();
    chk("state", {1'b0, state_o}, {1'b0, ms});
    chk("startTimer", 4'(start_o), 4'(mstart));
    chk("value", val_o, mval);
    chk("siren", 4'(siren_o), 4'(ms == SOUND_ALARM || ms == ALARM_HOLD));
    chk("statusLed", 4'(led_o), 4'(mled));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic pulse_exp();
    exp_in = 1'b1; cyc(1); exp_in = 1'b0;
  endtask

  task automatic pulse_hz();
    hz = 1'b1; cyc(1); hz = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ign = 1'b0; dd = 1'b0; pd = 1'b0; exp_in = 1'b0; hz = 1'b0;
`ifdef REPROGRAM_EN
    rp = 1'b0; psel = 2'd0; pval = 4'd0;
`endif
    cyc(2);
    chk("rst_state", {1'b0, state_o}, 4'(ARMED));
    chk("rst_value", val_o, 4'd0);
    chk("rst_siren", 4'(siren_o), 4'd0);
    chk("rst_led", 4'(led_o), 4'd0);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_start", 4'(start_o), 4'd0);

    // Driver door trigger, then expiry sounds the siren
    dd = 1'b1;
    cyc(2);
    chk("latency_armed", {1'b0, state_o}, 4'(ARMED));
    cyc(1);
    chk("drv_trig_state", {1'b0, state_o}, 4'(TRIGGERED));
    chk("drv_trig_start", 4'(start_o), 4'd1);
    chk("drv_trig_value", val_o, 4'd8);
    cyc(1);
    chk("start_one_cycle", 4'(start_o), 4'd0);
    chk("value_hold", val_o, 4'd8);
    pulse_exp();
    chk("sound_state", {1'b0, state_o}, 4'(SOUND_ALARM));
    chk("sound_siren", 4'(siren_o), 4'd1);
    chk("sound_led", 4'(led_o), 4'd1);

    // Hold, reopen, close, expire
    dd = 1'b0;
    cyc(3);
    chk("hold_state", {1'b0, state_o}, 4'(ALARM_HOLD));
    chk("hold_value", val_o, 4'd10);
    pulse_exp();
    chk("exp_on_start_ignored", {1'b0, state_o}, 4'(ALARM_HOLD));
    pd = 1'b1;
    cyc(3);
    chk("reopen_sound", {1'b0, state_o}, 4'(SOUND_ALARM));
    pd = 1'b0;
    cyc(4);
    pulse_exp();
    chk("hold_to_armed", {1'b0, state_o}, 4'(ARMED));
    chk("armed_siren_off", 4'(siren_o), 4'd0);
    chk("armed_led_off", 4'(led_o), 4'd0);
    pulse_hz();
    chk("led_toggle_on", 4'(led_o), 4'd1);
    pulse_hz();
    chk("led_toggle_off", 4'(led_o), 4'd0);

    // Both doors at once pick the driver interval; ignition disarms
    dd = 1'b1; pd = 1'b1;
    cyc(3);
    chk("both_doors_value", val_o, 4'd8);
    ign = 1'b1;
    cyc(3);
    chk("ign_disarmed", {1'b0, state_o}, 4'(DISARMED));
    chk("ign_siren", 4'(siren_o), 4'd0);
    pulse_exp();
    chk("disarmed_exp_ignored", {1'b0, state_o}, 4'(DISARMED));

    // Re-arming walk with an interrupted countdown
    ign = 1'b0; dd = 1'b0; pd = 1'b0;
    cyc(3);
    chk("wait_open", {1'b0, state_o}, 4'(WAIT_OPEN));
    dd = 1'b1;
    cyc(3);
    chk("wait_close", {1'b0, state_o}, 4'(WAIT_CLOSE));
    dd = 1'b0;
    cyc(3);
    chk("arming_state", {1'b0, state_o}, 4'(ARMING));
    chk("arming_value", val_o, 4'd6);
    dd = 1'b1;
    cyc(3);
    chk("arming_abandon", {1'b0, state_o}, 4'(WAIT_CLOSE));
    dd = 1'b0;
    cyc(4);
    pulse_exp();
    chk("arming_done", {1'b0, state_o}, 4'(ARMED));
    pulse_hz();
    chk("rearmed_led", 4'(led_o), 4'd1);

    // Passenger trigger then reset mid-countdown
    pd = 1'b1;
    cyc(3);
    chk("pas_trig_value", val_o, 4'd15);
    rst = 1'b1; pd = 1'b0;
    cyc(1);
    chk("midrst_state", {1'b0, state_o}, 4'(ARMED));
    chk("midrst_start", 4'(start_o), 4'd0);
    rst = 1'b0;
    cyc(1);
    chk("midrst_post_start", 4'(start_o), 4'd0);
    cyc(3);

`ifdef REPROGRAM_EN
    psel = 2'd1; pval = 4'd3; rp = 1'b1;
    cyc(1);
    rp = 1'b0;
    dd = 1'b1;
    cyc(3);
    chk("reprog_value", val_o, 4'd3);
    pulse_exp();
    dd = 1'b0;
    cyc(4);
    pulse_exp();
    psel = 2'd1; pval = 4'd0; rp = 1'b1;
    cyc(1);
    rp = 1'b0;
    dd = 1'b1;
    cyc(3);
    chk("reprog_default", val_o, 4'd8);
    dd = 1'b0;
`endif

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      rst    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) ign = ~ign;
      if ($urandom_range(0, 7) == 0)  dd  = ~dd;
      if ($urandom_range(0, 9) == 0)  pd  = ~pd;
      exp_in = ($urandom_range(0, 5) == 0);
      hz     = ($urandom_range(0, 3) == 0);
`ifdef REPROGRAM_EN
      rp   = ($urandom_range(0, 49) == 0);
      psel = 2'($urandom_range(0, 3));
      pval = 4'($urandom_range(0, 15));
`endif
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/anti_theft_fsm.md
ANTI_THEFT_FSM -- requirements
Module: anti_theft_fsm

Interface
REQ-001 SHALL have parameter T_ARM_DELAY, default 6, arming delay in seconds (4-bit).
REQ-002 SHALL have parameter T_DRIVER_DELAY, default 8, driver-door grace time (4-bit).
REQ-003 SHALL have parameter T_PASSENGER_DELAY, default 15, passenger-door grace time (4-bit).
REQ-004 SHALL have parameter T_ALARM_ON, default 10, siren hold time after doors close (4-bit).
REQ-005 SHALL have ports: clock in 1 system clock; reset in 1 synchronous active-high reset; one clock, reset synchronous and active-high.
REQ-006 SHALL have ports: ignition in 1, driverDoor in 1 (1=open), passengerDoor in 1 (1=open), all asynchronous switch inputs.
REQ-007 SHALL have ports: expired in 1 one-cycle timer-done pulse; clock1Hz in 1 one-cycle 1 Hz tick, both from the downstream timer.
REQ-008 SHALL have ports: startTimer out 1 one-cycle pulse; value out 4 selected interval; siren out 1; statusLed out 1; state out 3 debug.

Function
REQ-009 SHALL pass ignition/driverDoor/passengerDoor through a 2-flop synchronizer before use; FSM response latency 3 clock edges from input change.
REQ-010 SHALL implement states ARMED, TRIGGERED, SOUND_ALARM, ALARM_HOLD, DISARMED, WAIT_OPEN, WAIT_CLOSE, ARMING.
REQ-011 ARMED: driver door opens -> TRIGGERED with value=T_DRIVER_DELAY; else passenger door opens -> TRIGGERED with value=T_PASSENGER_DELAY; startTimer pulsed on transition.
REQ-012 Both doors opening same cycle in ARMED SHALL select T_DRIVER_DELAY.
REQ-013 TRIGGERED: ignition=1 -> DISARMED; expired -> SOUND_ALARM.
REQ-014 SOUND_ALARM: siren=1; when both doors closed -> ALARM_HOLD with value=T_ALARM_ON, startTimer pulsed.
REQ-015 ALARM_HOLD: siren=1; any door reopens -> SOUND_ALARM; expired -> ARMED, siren=0.
REQ-016 ignition=1 in any state SHALL force DISARMED next cycle, siren=0, highest priority.
REQ-017 DISARMED: ignition=0 -> WAIT_OPEN; WAIT_OPEN: driver door open -> WAIT_CLOSE; WAIT_CLOSE: driver door closed -> ARMING with value=T_ARM_DELAY, startTimer pulsed.
REQ-018 ARMING: any door open -> WAIT_CLOSE (countdown abandoned); expired -> ARMED.
REQ-019 startTimer SHALL be exactly one cycle wide, only on transitions into TRIGGERED, ALARM_HOLD, ARMING.
REQ-020 value SHALL be registered, update in the same cycle startTimer asserts, and hold until next startTimer.
REQ-021 expired SHALL be ignored in states not awaiting it and in the cycle startTimer is asserted.
REQ-022 statusLed: toggles on each clock1Hz pulse in ARMED; 1 in TRIGGERED, SOUND_ALARM, ALARM_HOLD; 0 otherwise; forced 0 on entering ARMED.
REQ-023 state output SHALL reflect current state register encoding from the package.

Reset
REQ-024 reset SHALL set state=ARMED, startTimer=0, value=0, siren=0, statusLed=0, synchronizers=0.
REQ-025 reset mid-countdown SHALL abandon it; no startTimer on the reset cycle or the first post-reset cycle.

Configuration
REQ-026 With REPROGRAM_EN defined: extra inputs reprogram(1), paramSel(2), paramValue(4); reprogram pulse loads paramValue into register selected by paramSel (0 arm,1 driver,2 passenger,3 alarm), takes effect at next startTimer; paramValue=0 loads parameter default; reset restores defaults.
REQ-027 Without REPROGRAM_EN: those ports absent, intervals are the parameter constants.

Structure
REQ-028 Package anti_theft_pkg SHALL hold state enum (3-bit), interval-select codes, default delay constants.
REQ-029 Sub-module time_parameters SHALL map interval select to 4-bit value and hold the REPROGRAM_EN registers.

Verification
REQ-030 Reset, driverDoor=1 -> TRIGGERED, startTimer pulse, value=8; expired -> siren=1.
REQ-031 ARMED, both doors open same cycle -> value=8; passenger only -> value=15.
REQ-032 TRIGGERED, ignition=1 before expired -> DISARMED, siren=0, later expired ignored.
REQ-033 SOUND_ALARM, doors close -> ALARM_HOLD value=10; door reopens -> SOUND_ALARM; close, expired -> ARMED, siren=0.
REQ-034 Ignition off, driver door open/close -> ARMING value=6; door reopen -> WAIT_CLOSE; close, expired -> ARMED, statusLed toggles per clock1Hz.
REQ-035 REPROGRAM_EN: paramSel=1, paramValue=3, reprogram -> next driver trigger value=3; paramValue=0 -> value=8.
